fetch_arbiter: RTL and testbench
================================

FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4, giving the number of compute-unit fetchers sharing one instruction-memory channel.
REQ-002 The block SHALL have parameter MEM_ADDR_WIDTH, default 8, giving the instruction address width.
REQ-003 The block SHALL have parameter MEM_DATA_WIDTH, default 16, giving the instruction word width.
REQ-004 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port fetch_req_val, input, NUM_CORES bits: per-core request valid.
REQ-008 The block SHALL have port fetch_req_addr, input, NUM_CORES*MEM_ADDR_WIDTH bits: per-core PC; core c occupies bits [c*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH].
REQ-009 The block SHALL have port fetch_req_rdy, output, NUM_CORES bits: per-core request accept.
REQ-010 The block SHALL have port fetch_resp_val, output, NUM_CORES bits: per-core response valid.
REQ-011 The block SHALL have port fetch_resp_inst, output, MEM_DATA_WIDTH bits: the instruction word, broadcast to all cores.
REQ-012 The block SHALL have port fetch_resp_rdy, input, NUM_CORES bits: per-core response ready.
REQ-013 The block SHALL have port mem2fetch_req_val, output, 1 bit: memory request valid.
REQ-014 The block SHALL have port mem2fetch_req_rdy, input, 1 bit: memory request ready.
REQ-015 The block SHALL have port mem2fetch_req_addr, output, MEM_ADDR_WIDTH bits: memory request address.
REQ-016 The block SHALL have port mem2fetch_resp_val, input, 1 bit: memory response valid.
REQ-017 The block SHALL have port mem2fetch_resp_rdy, output, 1 bit: memory response ready.
REQ-018 The block SHALL have port mem2fetch_resp_inst, input, MEM_DATA_WIDTH bits: memory response data.
REQ-019 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-020 The block SHALL have port grant_id, output, $clog2(NUM_CORES) bits: the core currently owning the channel.

Function
REQ-021 The block SHALL implement a four-state FSM: IDLE, MEM_REQ, MEM_WAIT, CORE_RESP.
REQ-022 In IDLE, when any fetch_req_val bit is set, the block SHALL select the first set bit at or after rr_ptr, searching upward with wrap-around.
REQ-023 In that same IDLE cycle, the block SHALL drive fetch_req_rdy[sel]=1 combinationally, latch the selected address and sel, and move to MEM_REQ; all other fetch_req_rdy bits SHALL remain 0.
REQ-024 In MEM_REQ, the block SHALL hold mem2fetch_req_val=1 with the latched address stable until the cycle in which mem2fetch_req_rdy=1, then move to MEM_WAIT.
REQ-025 In MEM_WAIT, the block SHALL drive mem2fetch_resp_rdy=1; on mem2fetch_resp_val=1 it SHALL latch mem2fetch_resp_inst and move to CORE_RESP.
REQ-026 mem2fetch_resp_val in any state other than MEM_WAIT SHALL be ignored, and mem2fetch_resp_rdy SHALL be 0 outside MEM_WAIT.
REQ-027 In CORE_RESP, the block SHALL drive fetch_resp_val[grant_id]=1 and fetch_resp_inst=the latched word; when fetch_resp_rdy[grant_id]=1 it SHALL set rr_ptr=(grant_id+1) mod NUM_CORES and return to IDLE.
REQ-028 fetch_resp_rdy bits of non-granted cores SHALL be ignored.
REQ-029 At most one transaction SHALL be outstanding; fetch_req_rdy SHALL be all-zero outside IDLE.
REQ-030 Minimum latency with zero-wait memory and core SHALL be: accept at cycle 0, mem request at cycle 1, response captured at cycle 2, core response at cycle 3, back in IDLE at cycle 4.
REQ-031 A request that drops fetch_req_val before it is accepted SHALL NOT be granted.
REQ-032 Round-robin SHALL guarantee that any continuously asserting core is granted within NUM_CORES transactions.
REQ-033 When outputs are not active, mem2fetch_req_addr and fetch_resp_inst SHALL hold their last latched values, and grant_id SHALL hold the last grant.

Reset
REQ-034 On reset=1 at a clock edge, the block SHALL set state=IDLE, rr_ptr=0, grant_id=0, latched address=0 and latched instruction=0.
REQ-035 While reset=1, all val/rdy outputs and busy SHALL be 0.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction without signalling completion; a memory response arriving after reset SHALL be ignored (IDLE).

Verification
REQ-037 Single request: core 2 requests addr 0x1A, memory ready immediately and returns 0xBEEF one cycle later -> mem2fetch_req_addr=0x1A at cycle 1, fetch_resp_val=4'b0100 with inst 0xBEEF at cycle 3, busy low at cycle 4.
REQ-038 All four cores request continuously with rr_ptr=0 -> grant order 0,1,2,3,0; each response is delivered only to the granted core.
REQ-039 Backpressure: mem2fetch_req_rdy held low 3 cycles, then fetch_resp_rdy held low 2 cycles -> mem2fetch_req_val and address stable 4 cycles, fetch_resp_val and inst stable 3 cycles, no new grant meanwhile.
REQ-040 Spurious response: mem2fetch_resp_val=1 pulsed with data 0x1234 in IDLE and in MEM_REQ -> no state change, no data latched.
REQ-041 Reset in MEM_WAIT, then memory returns data -> next cycle state IDLE, rr_ptr=0, no fetch_resp_val asserted.
REQ-042 Wrap-around: rr_ptr=3 with cores 1 and 3 requesting -> core 3 granted first, then core 1.

Source files
------------

// File: rtl/fetch_arbiter_if.sv
// Fetch channel bundle: per-core fetch request/response plus the shared
// instruction-memory request/response handshake.
interface fetch_arbiter_if #(
    parameter int NUM_CORES      = 4,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 16
);
    logic [NUM_CORES-1:0]                fetch_req_val;
    logic [NUM_CORES*MEM_ADDR_WIDTH-1:0] fetch_req_addr;
    logic [NUM_CORES-1:0]                fetch_req_rdy;
    logic [NUM_CORES-1:0]                fetch_resp_val;
    logic [MEM_DATA_WIDTH-1:0]           fetch_resp_inst;
    logic [NUM_CORES-1:0]                fetch_resp_rdy;
    logic                                mem2fetch_req_val;
    logic                                mem2fetch_req_rdy;
    logic [MEM_ADDR_WIDTH-1:0]           mem2fetch_req_addr;
    logic                                mem2fetch_resp_val;
    logic                                mem2fetch_resp_rdy;
    logic [MEM_DATA_WIDTH-1:0]           mem2fetch_resp_inst;

    modport slave (
        input  fetch_req_val,
        input  fetch_req_addr,
        output fetch_req_rdy,
        output fetch_resp_val,
        output fetch_resp_inst,
        input  fetch_resp_rdy,
        output mem2fetch_req_val,
        input  mem2fetch_req_rdy,
        output mem2fetch_req_addr,
        input  mem2fetch_resp_val,
        output mem2fetch_resp_rdy,
        input  mem2fetch_resp_inst
    );

    modport master (
        output fetch_req_val,
        output fetch_req_addr,
        input  fetch_req_rdy,
        input  fetch_resp_val,
        input  fetch_resp_inst,
        output fetch_resp_rdy,
        input  mem2fetch_req_val,
        output mem2fetch_req_rdy,
        input  mem2fetch_req_addr,
        output mem2fetch_resp_val,
        input  mem2fetch_resp_rdy,
        output mem2fetch_resp_inst
    );
endinterface

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one instruction-memory channel among
// NUM_CORES fetchers; one transaction in flight at a time.
module fetch_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 16,
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    fetch_arbiter_if.slave bus,
    output logic          busy,
    output logic [GW-1:0] grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        CORE_RESP
    } state_t;

    state_t                    state_q, state_d;
    logic [GW-1:0]             rr_q, rr_d;
    logic [GW-1:0]             grant_q, grant_d;
    logic [GW-1:0]             sel;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d, addr_sel;
    logic [MEM_DATA_WIDTH-1:0] inst_q, inst_d;
    logic                      any_req;

    // Walk downward so the candidate closest to rr_q wins last.
    always_comb begin : pick
        logic [GW-1:0] idx;
        idx     = '0;
        sel     = rr_q;
        any_req = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            idx = GW'((int'(rr_q) + i) % NUM_CORES);
            if (bus.fetch_req_val[idx]) begin
                sel     = idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin : addr_mux
        addr_sel = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (sel == GW'(c)) begin
                addr_sel = bus.fetch_req_addr[c*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
            end
        end
    end

    always_comb begin : fsm
        state_d                = state_q;
        rr_d                   = rr_q;
        grant_d                = grant_q;
        addr_d                 = addr_q;
        inst_d                 = inst_q;
        bus.fetch_req_rdy      = '0;
        bus.fetch_resp_val     = '0;
        bus.mem2fetch_req_val  = 1'b0;
        bus.mem2fetch_resp_rdy = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    bus.fetch_req_rdy = NUM_CORES'(1) << sel;
                    grant_d           = sel;
                    addr_d            = addr_sel;
                    state_d           = MEM_REQ;
                end
            end
            MEM_REQ: begin
                bus.mem2fetch_req_val = 1'b1;
                if (bus.mem2fetch_req_rdy) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                bus.mem2fetch_resp_rdy = 1'b1;
                if (bus.mem2fetch_resp_val) begin
                    inst_d  = bus.mem2fetch_resp_inst;
                    state_d = CORE_RESP;
                end
            end
            CORE_RESP: begin
                bus.fetch_resp_val = NUM_CORES'(1) << grant_q;
                if (bus.fetch_resp_rdy[grant_q]) begin
                    rr_d    = (grant_q == GW'(NUM_CORES - 1)) ? '0
                                                              : grant_q + GW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshakes stay quiet for the whole reset window.
        if (reset) begin
            bus.fetch_req_rdy      = '0;
            bus.fetch_resp_val     = '0;
            bus.mem2fetch_req_val  = 1'b0;
            bus.mem2fetch_resp_rdy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
        end
    end

    assign busy                   = (state_q != IDLE) && !reset;
    assign grant_id               = grant_q;
    assign bus.mem2fetch_req_addr = addr_q;
    assign bus.fetch_resp_inst    = inst_q;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Self-checking bench for fetch_arbiter: directed scenarios plus a
// scoreboard of expected (core, instruction) responses.
module tb_fetch_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [1:0] grant_id;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [1:0]  core;
        logic [15:0] inst;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    fetch_arbiter_if #(.NUM_CORES(4), .MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(16)) bus();

    fetch_arbiter #(
        .NUM_CORES(4),
        .MEM_ADDR_WIDTH(8),
        .MEM_DATA_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .grant_id(grant_id)
    );

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {~a, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.fetch_req_val       = '0;
        bus.fetch_resp_rdy      = '0;
        bus.mem2fetch_req_rdy   = 1'b0;
        bus.mem2fetch_resp_val  = 1'b0;
        bus.mem2fetch_resp_inst = '0;
    endtask

    task automatic set_addrs();
        for (int c = 0; c < 4; c++) begin
            bus.fetch_req_addr[c*8 +: 8] = 8'(8'h40 + c);
        end
    endtask

    // Plays memory and the granted core for one transaction; reports what it saw.
    task automatic xact(input int md, input int cd,
                        output logic [3:0] rv, output logic [15:0] ri,
                        output logic [1:0] gid, output bit to);
        int n;
        logic [7:0] a;
        to = 1'b0;
        n  = 0;
        #1;
        while (bus.fetch_req_rdy == 4'b0 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) to = 1'b1;
        step();
        bus.mem2fetch_req_rdy = 1'b0;
        for (int i = 0; i < md; i++) step();
        bus.mem2fetch_req_rdy = 1'b1;
        a = bus.mem2fetch_req_addr;
        step();
        bus.mem2fetch_req_rdy   = 1'b0;
        bus.mem2fetch_resp_val  = 1'b1;
        bus.mem2fetch_resp_inst = mem_word(a);
        step();
        bus.mem2fetch_resp_val = 1'b0;
        n = 0;
        while (bus.fetch_resp_val == 4'b0 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) to = 1'b1;
        rv  = bus.fetch_resp_val;
        ri  = bus.fetch_resp_inst;
        gid = grant_id;
        for (int i = 0; i < cd; i++) step();
        bus.fetch_resp_rdy = rv;
        step();
        bus.fetch_resp_rdy = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        set_addrs();
        bus.fetch_req_val      = 4'hF;
        bus.mem2fetch_req_rdy  = 1'b1;
        bus.mem2fetch_resp_val = 1'b1;
        bus.fetch_resp_rdy     = 4'hF;
        reset = 1'b1;
        step();
        step();
        #1;
        total++;
        if ({bus.fetch_req_rdy, bus.fetch_resp_val, bus.mem2fetch_req_val,
             bus.mem2fetch_resp_rdy, busy} !== 11'b0)
            $display("FAIL rst_outputs: got %b want 0",
                     {bus.fetch_req_rdy, bus.fetch_resp_val, bus.mem2fetch_req_val,
                      bus.mem2fetch_resp_rdy, busy});
        else passed++;
        idle_inputs();
        reset = 1'b0;
        step();
        #1;
        total++;
        if (grant_id !== 2'd0)
            $display("FAIL rst_grant: got %0d want 0", grant_id);
        else passed++;
        total++;
        if (bus.mem2fetch_req_addr !== 8'h00)
            $display("FAIL rst_addr: got %h want 00", bus.mem2fetch_req_addr);
        else passed++;
        total++;
        if (bus.fetch_resp_inst !== 16'h0000)
            $display("FAIL rst_inst: got %h want 0000", bus.fetch_resp_inst);
        else passed++;
    endtask

    task automatic test_single();
        bus.fetch_req_addr[2*8 +: 8] = 8'h1A;
        bus.fetch_req_val     = 4'b0100;
        bus.mem2fetch_req_rdy = 1'b1;
        #1;
        total++;
        if (bus.fetch_req_rdy !== 4'b0100 || busy !== 1'b0)
            $display("FAIL single_accept: got rdy=%b busy=%b want 0100/0",
                     bus.fetch_req_rdy, busy);
        else passed++;
        step();
        bus.fetch_req_val = '0;
        #1;
        total++;
        if ({bus.mem2fetch_req_val, bus.mem2fetch_req_addr, grant_id, busy}
            !== {1'b1, 8'h1A, 2'd2, 1'b1})
            $display("FAIL single_memreq: got val=%b addr=%h gid=%0d busy=%b want 1/1a/2/1",
                     bus.mem2fetch_req_val, bus.mem2fetch_req_addr, grant_id, busy);
        else passed++;
        step();
        bus.mem2fetch_resp_val  = 1'b1;
        bus.mem2fetch_resp_inst = 16'hBEEF;
        #1;
        total++;
        if (bus.mem2fetch_resp_rdy !== 1'b1)
            $display("FAIL single_resp_rdy: got %b want 1", bus.mem2fetch_resp_rdy);
        else passed++;
        step();
        bus.mem2fetch_resp_val = 1'b0;
        bus.fetch_resp_rdy     = 4'b0100;
        #1;
        total++;
        if (bus.fetch_resp_val !== 4'b0100 || bus.fetch_resp_inst !== 16'hBEEF)
            $display("FAIL single_core_resp: got %b/%h want 0100/beef",
                     bus.fetch_resp_val, bus.fetch_resp_inst);
        else passed++;
        step();
        bus.fetch_resp_rdy    = '0;
        bus.mem2fetch_req_rdy = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || bus.fetch_resp_val !== 4'b0)
            $display("FAIL single_done: got busy=%b val=%b want 0/0000",
                     busy, bus.fetch_resp_val);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0]  rv;
        logic [15:0] ri;
        logic [1:0]  gid;
        bit          to;
        exp_t        e;
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_addrs();
        bus.fetch_req_val = 4'hF;
        for (int k = 0; k < 5; k++) begin
            e.core = 2'(k % 4);
            e.inst = mem_word(8'(8'h40 + (k % 4)));
            sbq.push_back(e);
        end
        for (int k = 0; k < 5; k++) begin
            xact(0, 0, rv, ri, gid, to);
            e = sbq.pop_front();
            total++;
            if (to) $display("FAIL rr_timeout: txn %0d got timeout want response", k);
            else passed++;
            total++;
            if (rv !== (4'b0001 << e.core) || ri !== e.inst || gid !== e.core)
                $display("FAIL rr_grant: txn %0d got val=%b inst=%h gid=%0d want core %0d inst %h",
                         k, rv, ri, gid, e.core, e.inst);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        #1;
        total++;
        if (bus.fetch_req_rdy !== 4'b0010)
            $display("FAIL bp_accept: got %b want 0010", bus.fetch_req_rdy);
        else passed++;
        step();
        bus.mem2fetch_req_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem2fetch_req_rdy = 1'b1;
            #1;
            total++;
            if ({bus.mem2fetch_req_val, bus.mem2fetch_req_addr, bus.fetch_req_rdy}
                !== {1'b1, 8'h41, 4'b0})
                $display("FAIL bp_memreq: cycle %0d got val=%b addr=%h rdy=%b want 1/41/0000",
                         i, bus.mem2fetch_req_val, bus.mem2fetch_req_addr, bus.fetch_req_rdy);
            else passed++;
            step();
        end
        bus.mem2fetch_req_rdy   = 1'b0;
        bus.mem2fetch_resp_val  = 1'b1;
        bus.mem2fetch_resp_inst = 16'hC0DE;
        step();
        bus.mem2fetch_resp_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.fetch_resp_rdy = (i == 2) ? 4'b0010 : 4'b1101;
            if (i == 2) bus.fetch_req_val = '0;
            #1;
            total++;
            if ({bus.fetch_resp_val, bus.fetch_resp_inst, bus.fetch_req_rdy, grant_id}
                !== {4'b0010, 16'hC0DE, 4'b0, 2'd1})
                $display("FAIL bp_coreresp: cycle %0d got val=%b inst=%h rdy=%b gid=%0d want 0010/c0de/0000/1",
                         i, bus.fetch_resp_val, bus.fetch_resp_inst, bus.fetch_req_rdy, grant_id);
            else passed++;
            step();
        end
        bus.fetch_resp_rdy = '0;
        #1;
        total++;
        if (busy !== 1'b0)
            $display("FAIL bp_done: got busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_spurious();
        bus.mem2fetch_resp_val  = 1'b1;
        bus.mem2fetch_resp_inst = 16'h1234;
        #1;
        total++;
        if (bus.mem2fetch_resp_rdy !== 1'b0)
            $display("FAIL spur_idle_rdy: got %b want 0", bus.mem2fetch_resp_rdy);
        else passed++;
        step();
        bus.mem2fetch_resp_val = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || bus.fetch_resp_inst !== 16'hC0DE)
            $display("FAIL spur_idle: got busy=%b inst=%h want 0/c0de",
                     busy, bus.fetch_resp_inst);
        else passed++;
        bus.fetch_req_val     = 4'b0100;
        bus.mem2fetch_req_rdy = 1'b0;
        step();
        bus.fetch_req_val       = '0;
        bus.mem2fetch_resp_val  = 1'b1;
        bus.mem2fetch_resp_inst = 16'h1234;
        #1;
        total++;
        if (bus.mem2fetch_resp_rdy !== 1'b0)
            $display("FAIL spur_memreq_rdy: got %b want 0", bus.mem2fetch_resp_rdy);
        else passed++;
        step();
        bus.mem2fetch_resp_val = 1'b0;
        #1;
        total++;
        if (bus.mem2fetch_req_val !== 1'b1 || bus.mem2fetch_req_addr !== 8'h42)
            $display("FAIL spur_memreq_hold: got val=%b addr=%h want 1/42",
                     bus.mem2fetch_req_val, bus.mem2fetch_req_addr);
        else passed++;
        bus.mem2fetch_req_rdy = 1'b1;
        step();
        bus.mem2fetch_req_rdy   = 1'b0;
        bus.mem2fetch_resp_val  = 1'b1;
        bus.mem2fetch_resp_inst = 16'h5678;
        step();
        bus.mem2fetch_resp_val = 1'b0;
        #1;
        total++;
        if (bus.fetch_resp_val !== 4'b0100 || bus.fetch_resp_inst !== 16'h5678)
            $display("FAIL spur_data: got %b/%h want 0100/5678",
                     bus.fetch_resp_val, bus.fetch_resp_inst);
        else passed++;
        bus.fetch_resp_rdy = 4'b0100;
        step();
        bus.fetch_resp_rdy = '0;
    endtask

    task automatic test_reset_mid();
        logic [3:0]  rv;
        logic [15:0] ri;
        logic [1:0]  gid;
        bit          to;
        exp_t        e;
        bus.fetch_req_val     = 4'b0001;
        bus.mem2fetch_req_rdy = 1'b1;
        step();
        bus.fetch_req_val = '0;
        step();
        bus.mem2fetch_req_rdy = 1'b0;
        #1;
        total++;
        if (bus.mem2fetch_resp_rdy !== 1'b1)
            $display("FAIL rmid_wait: got resp_rdy=%b want 1", bus.mem2fetch_resp_rdy);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if ({busy, bus.mem2fetch_resp_rdy} !== 2'b00)
            $display("FAIL rmid_during: got busy/rdy=%b want 00",
                     {busy, bus.mem2fetch_resp_rdy});
        else passed++;
        step();
        reset = 1'b0;
        bus.mem2fetch_resp_val  = 1'b1;
        bus.mem2fetch_resp_inst = 16'h9999;
        #1;
        total++;
        if ({busy, bus.mem2fetch_resp_rdy, bus.fetch_resp_val} !== 6'b0)
            $display("FAIL rmid_after: got busy/rdy/val=%b want 0",
                     {busy, bus.mem2fetch_resp_rdy, bus.fetch_resp_val});
        else passed++;
        step();
        bus.mem2fetch_resp_val = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || bus.fetch_resp_val !== 4'b0 || bus.fetch_resp_inst !== 16'h0)
            $display("FAIL rmid_ignored: got busy=%b val=%b inst=%h want 0/0000/0000",
                     busy, bus.fetch_resp_val, bus.fetch_resp_inst);
        else passed++;
        bus.fetch_req_val = 4'b1010;
        #1;
        total++;
        if (bus.fetch_req_rdy !== 4'b0010)
            $display("FAIL rmid_rrptr: got %b want 0010", bus.fetch_req_rdy);
        else passed++;
        e.core = 2'd1;
        e.inst = mem_word(8'h41);
        sbq.push_back(e);
        xact(1, 1, rv, ri, gid, to);
        bus.fetch_req_val = '0;
        e = sbq.pop_front();
        total++;
        if (to || rv !== (4'b0001 << e.core) || ri !== e.inst)
            $display("FAIL rmid_xact: got to=%b val=%b inst=%h want core %0d inst %h",
                     to, rv, ri, e.core, e.inst);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [3:0]  rv;
        logic [15:0] ri;
        logic [1:0]  gid;
        bit          to;
        exp_t        e;
        bus.fetch_req_val = 4'b0100;
        e.core = 2'd2; e.inst = mem_word(8'h42); sbq.push_back(e);
        e.core = 2'd3; e.inst = mem_word(8'h43); sbq.push_back(e);
        e.core = 2'd1; e.inst = mem_word(8'h41); sbq.push_back(e);
        for (int k = 0; k < 3; k++) begin
            xact(0, 0, rv, ri, gid, to);
            bus.fetch_req_val = (k < 2) ? 4'b1010 : 4'b0000;
            e = sbq.pop_front();
            total++;
            if (to || rv !== (4'b0001 << e.core) || ri !== e.inst || gid !== e.core)
                $display("FAIL wrap_grant: txn %0d got to=%b val=%b inst=%h gid=%0d want core %0d inst %h",
                         k, to, rv, ri, gid, e.core, e.inst);
            else passed++;
        end
        total++;
        if (sbq.size() != 0)
            $display("FAIL sb_drain: got %0d left want 0", sbq.size());
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        bus.fetch_req_addr = '0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
